// File: rtl/alu_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALU operation encoding used by the alu and its sequencers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

   typedef enum logic [3:0] {
      ALUOP_AND = 4'd0,
      ALUOP_ADD = 4'd1,
      ALUOP_SUB = 4'd2,
      ALUOP_INC = 4'd3,
      ALUOP_DEC = 4'd4,
      ALUOP_NEG = 4'd5,
      ALUOP_ROL = 4'd6,
      ALUOP_ROR = 4'd7
   } alu_op_e;

endpackage : alu_pkg

`default_nettype wire

// File: rtl/alu.sv
// ============================================================================
// Module      : alu
// Description : 16-bit combinational ALU; rotates move one bit per operation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu
   import alu_pkg::*;
(
   input  logic [3:0]  i_op,
   input  logic [15:0] i_a,
   input  logic [15:0] i_b,
   output logic [15:0] o_r
);

   always_comb begin
      o_r = 16'h0000;
      case (i_op)
         ALUOP_AND: o_r = i_a & i_b;
         ALUOP_ADD: o_r = i_a + i_b;
         ALUOP_SUB: o_r = i_a - i_b;
         ALUOP_INC: o_r = i_a + 16'd1;
         ALUOP_DEC: o_r = i_a - 16'd1;
         ALUOP_NEG: o_r = 16'h0000 - i_a;
         ALUOP_ROL: o_r = {i_a[14:0], i_a[15]};
         ALUOP_ROR: o_r = {i_a[0], i_a[15:1]};
         default:   o_r = 16'h0000;
      endcase
   end

endmodule : alu

`default_nettype wire

// File: rtl/alu_rot_seq.sv
// ============================================================================
// Module      : alu_rot_seq
// Description : Multi-bit rotate built from repeated single-bit ALU rotates.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_rot_seq
   import alu_pkg::*;
#(
   parameter int                 COUNT_W    = 8,
   parameter logic [COUNT_W-1:0] COUNT_MASK = COUNT_W'(8'h1F)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               dir,
   input  logic [15:0]        operand,
   input  logic [COUNT_W-1:0] count,
   input  logic               abort,
   output logic               busy,
   output logic               done,
   output logic [15:0]        result,
   output logic [3:0]         alu_op,
   output logic [15:0]        alu_a,
   output logic [15:0]        alu_b,
   input  logic [15:0]        alu_r
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [15:0]        acc_q, acc_d;
   logic [COUNT_W-1:0] cnt_q, cnt_d;
   logic               dir_q, dir_d;
   logic [15:0]        result_q, result_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         acc_q    <= 16'h0000;
         cnt_q    <= '0;
         dir_q    <= 1'b0;
         result_q <= 16'h0000;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         dir_q    <= dir_d;
         result_q <= result_d;
      end
   end

   // result is captured on the edge entering DONE so it is stable for the whole done cycle
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      dir_d    = dir_q;
      result_d = result_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               acc_d = operand;
               cnt_d = count & COUNT_MASK;
               dir_d = dir;
               if ((count & COUNT_MASK) == '0) begin
                  state_d  = S_DONE;
                  result_d = operand;
               end else begin
                  state_d = S_RUN;
               end
            end
         end
         S_RUN: begin
            if (abort) begin
               state_d = S_IDLE;
            end else begin
               acc_d = alu_r;
               cnt_d = cnt_q - COUNT_W'(1);
               if (cnt_q == COUNT_W'(1)) begin
                  state_d  = S_DONE;
                  result_d = alu_r;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign busy   = (state_q != S_IDLE);
   assign done   = (state_q == S_DONE);
   assign result = result_q;
   assign alu_op = (state_q == S_RUN) ? (dir_q ? ALUOP_ROR : ALUOP_ROL) : ALUOP_AND;
   assign alu_a  = (state_q == S_RUN) ? acc_q : 16'h0000;
   assign alu_b  = 16'h0000;

endmodule : alu_rot_seq

`default_nettype wire

// File: tb/tb_alu_rot_seq.sv
// ============================================================================
// Module      : tb_alu_rot_seq
// Description : Self-checking bench for alu_rot_seq driving the real alu.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_rot_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        dir;
   logic [15:0] operand;
   logic [7:0]  count;
   logic        abort;
   logic        busy;
   logic        done;
   logic [15:0] result;
   logic [3:0]  alu_op;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic [15:0] alu_r;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   alu_rot_seq dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .dir     (dir),
      .operand (operand),
      .count   (count),
      .abort   (abort),
      .busy    (busy),
      .done    (done),
      .result  (result),
      .alu_op  (alu_op),
      .alu_a   (alu_a),
      .alu_b   (alu_b),
      .alu_r   (alu_r)
   );

   alu u_alu (
      .i_op (alu_op),
      .i_a  (alu_a),
      .i_b  (alu_b),
      .o_r  (alu_r)
   );

   // Rotate by n bit positions using a doubled word window
   function automatic logic [15:0] rot(input logic [15:0] v, input bit right, input int n);
      logic [31:0] dbl;
      int          m;
      dbl = {v, v};
      m   = n % 16;
      if (right) return dbl[m +: 16];
      return dbl[(16 - m) +: 16];
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag, input logic [15:0] exp_result);
      chk({tag, "_busy"}, {15'd0, busy}, 16'd0);
      chk({tag, "_done"}, {15'd0, done}, 16'd0);
      chk({tag, "_result"}, result, exp_result);
      chk({tag, "_op"}, {12'd0, alu_op}, 16'd0);
      chk({tag, "_a"}, alu_a, 16'h0000);
   endtask

   // Launch one rotate at the next edge and check every cycle through to idle
   task automatic run_op(input bit d, input logic [15:0] op, input logic [7:0] c, input int stray_at);
      int          n;
      logic [15:0] exp_r;
      n     = int'(c) % 32;
      exp_r = rot(op, d, n);
      start = 1'b1; dir = d; operand = op; count = c;
      @(negedge clk);
      start = 1'b0; dir = ~d; operand = 16'($urandom); count = 8'($urandom);
      for (int i = 1; i <= n; i++) begin
         chk("run_busy", {15'd0, busy}, 16'd1);
         chk("run_done", {15'd0, done}, 16'd0);
         chk("run_op", {12'd0, alu_op}, d ? 16'd7 : 16'd6);
         chk("run_a", alu_a, rot(op, d, i - 1));
         chk("run_b", alu_b, 16'h0000);
         if (i == stray_at) begin
            start = 1'b1; dir = ~d; operand = 16'($urandom); count = 8'($urandom);
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
      chk("done_pulse", {15'd0, done}, 16'd1);
      chk("done_busy", {15'd0, busy}, 16'd1);
      chk("done_result", result, exp_r);
      chk("done_op", {12'd0, alu_op}, 16'd0);
      @(negedge clk);
      check_idle("post", exp_r);
   endtask

   initial begin
      logic [15:0] prev;
      reset = 1'b1; start = 1'b0; dir = 1'b0; operand = 16'h0; count = 8'h0; abort = 1'b0;
      repeat (3) @(negedge clk);
      check_idle("in_reset", 16'h0000);
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check_idle("idle", 16'h0000);
      end

      run_op(1'b0, 16'h8001, 8'd1, 0);
      run_op(1'b1, 16'h0001, 8'd4, 0);
      run_op(1'b0, 16'hABCD, 8'd0, 0);
      run_op(1'b0, 16'h8001, 8'd21, 0);
      run_op(1'b0, 16'h1234, 8'd16, 5);
      run_op(1'b1, 16'hC35A, 8'd31, 0);

      // Abort mid-run: no done, previous result retained
      run_op(1'b1, 16'h00F0, 8'd3, 0);
      prev  = result;
      start = 1'b1; dir = 1'b0; operand = 16'($urandom); count = 8'd8;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check_idle("abort", prev);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("abort_nodone", {15'd0, done}, 16'd0);
      end

      // start together with abort in IDLE launches the operation
      start = 1'b1; abort = 1'b1; dir = 1'b0; operand = 16'h4001; count = 8'd2;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      chk("sa_busy", {15'd0, busy}, 16'd1);
      chk("sa_op", {12'd0, alu_op}, 16'd6);
      @(negedge clk);
      @(negedge clk);
      chk("sa_done", {15'd0, done}, 16'd1);
      chk("sa_result", result, 16'h0005);
      @(negedge clk);

      // Asynchronous reset in the middle of a run
      start = 1'b1; dir = 1'b1; operand = 16'hFFFE; count = 8'd10;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      #1 reset = 1'b1;
      #1 check_idle("async_rst", 16'h0000);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_idle("after_rst", 16'h0000);

      for (int t = 0; t < 24; t++) begin
         run_op(1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom_range(0, 255)),
                int'($urandom_range(0, 40)));
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_alu_rot_seq

`default_nettype wire
